// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: read port pair, write port, issue
// (scoreboard set) port and the hazard outputs.
interface reg_file_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              rd_en;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] data_out0;
    logic [DATA_W-1:0] data_out1;
    logic              wr_en;
    logic [ADDR_W-1:0] wd_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic              busy_a;
    logic              busy_b;
    logic              stall;

    modport master (
        output rd_en, ra, rb, wr_en, wd_addr, wr_data, issue_en, issue_addr,
        input  data_out0, data_out1, busy_a, busy_b, stall
    );

    modport slave (
        input  rd_en, ra, rb, wr_en, wd_addr, wr_data, issue_en, issue_addr,
        output data_out0, data_out1, busy_a, busy_b, stall
    );
endinterface

// File: rtl/reg_file_param.sv
// Two-read / one-write register file with registered read data, optional
// write-to-read forwarding, optional hardwired-zero entry 0 and a per-entry
// busy scoreboard driving a read-hazard stall.
module reg_file_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input logic              clk,
    input logic              reset,
    reg_file_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BYP   = (BYPASS != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic              wr_ok;
    logic              fwd_a;
    logic              fwd_b;
    logic              zero_a;
    logic              zero_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // A write to the hardwired zero entry is dropped, so it can never be
    // stored nor forwarded.
    assign wr_ok  = bus.wr_en && !(ZR && (bus.wd_addr == '0));
    assign fwd_a  = BYP && wr_ok && (bus.wd_addr == bus.ra);
    assign fwd_b  = BYP && wr_ok && (bus.wd_addr == bus.rb);
    assign zero_a = ZR && (bus.ra == '0);
    assign zero_b = ZR && (bus.rb == '0);

    // Read-port selection: zero entry, forwarded write data, or stored entry.
    always_comb begin
        rd_a = mem[bus.ra];
        rd_b = mem[bus.rb];
        if (fwd_a) rd_a = bus.wr_data;
        if (fwd_b) rd_b = bus.wr_data;
        if (zero_a) rd_a = '0;
        if (zero_b) rd_b = '0;
    end

    // Pending status is masked when the producer's write lands this cycle
    // and will be forwarded.
    assign bus.busy_a = busy[bus.ra] && !(BYP && bus.wr_en && (bus.wd_addr == bus.ra)) && !zero_a;
    assign bus.busy_b = busy[bus.rb] && !(BYP && bus.wr_en && (bus.wd_addr == bus.rb)) && !zero_b;
    assign bus.stall  = bus.rd_en && (bus.busy_a || bus.busy_b);

    // Storage array update; reset clears every entry and overrides writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[bus.wd_addr] <= bus.wr_data;
        end
    end

    // Scoreboard: a write clears, an issue sets; the set is applied last so
    // a new producer supersedes a completing one on the same entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (bus.wr_en) busy[bus.wd_addr] <= 1'b0;
            if (bus.issue_en && !(ZR && (bus.issue_addr == '0)))
                busy[bus.issue_addr] <= 1'b1;
        end
    end

    // Registered read data, captured even while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_out0 <= '0;
            bus.data_out1 <= '0;
        end else if (bus.rd_en) begin
            bus.data_out0 <= rd_a;
            bus.data_out1 <= rd_b;
        end
    end
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances share one stimulus stream,
// dut_a (ZERO_REG=0, BYPASS=1) and dut_b (ZERO_REG=1, BYPASS=0). Expected
// values are queued by the stimulus and checked by an independent monitor.
module tb_reg_file_param;
    logic       clk = 1'b0;
    logic       reset;
    logic       rd_en, wr_en, issue_en;
    logic [3:0] ra, rb, wd_addr, issue_addr;
    logic [7:0] wr_data;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      nm;
        logic [7:0] a0, a1, b0, b1;
    } dexp_t;

    typedef struct {
        string nm;
        logic  a_ba, a_bb, a_st;
        logic  b_ba, b_bb, b_st;
    } cexp_t;

    dexp_t dq[$];
    cexp_t cq[$];
    logic  chk_c = 1'b0;
    logic  chk_d = 1'b0;
    logic  chk_dq = 1'b0;

    reg_file_param_if #(.DATA_W(8), .ADDR_W(4)) bus_a ();
    reg_file_param_if #(.DATA_W(8), .ADDR_W(4)) bus_b ();

    assign bus_a.rd_en = rd_en;        assign bus_b.rd_en = rd_en;
    assign bus_a.ra = ra;              assign bus_b.ra = ra;
    assign bus_a.rb = rb;              assign bus_b.rb = rb;
    assign bus_a.wr_en = wr_en;        assign bus_b.wr_en = wr_en;
    assign bus_a.wd_addr = wd_addr;    assign bus_b.wd_addr = wd_addr;
    assign bus_a.wr_data = wr_data;    assign bus_b.wr_data = wr_data;
    assign bus_a.issue_en = issue_en;  assign bus_b.issue_en = issue_en;
    assign bus_a.issue_addr = issue_addr; assign bus_b.issue_addr = issue_addr;

    reg_file_param #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    reg_file_param #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Data expectation becomes due one edge after it was issued.
    always @(posedge clk) chk_dq <= chk_d;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge clk) begin
        if (chk_c) begin
            if (cq.size() == 0) begin
                n_assert++; n_fail++;
                $display("FAIL comb_queue: got empty expected entry");
            end else begin
                cexp_t e;
                e = cq.pop_front();
                check({e.nm, ".a.busy_a"}, {7'd0, bus_a.busy_a}, {7'd0, e.a_ba});
                check({e.nm, ".a.busy_b"}, {7'd0, bus_a.busy_b}, {7'd0, e.a_bb});
                check({e.nm, ".a.stall"},  {7'd0, bus_a.stall},  {7'd0, e.a_st});
                check({e.nm, ".b.busy_a"}, {7'd0, bus_b.busy_a}, {7'd0, e.b_ba});
                check({e.nm, ".b.busy_b"}, {7'd0, bus_b.busy_b}, {7'd0, e.b_bb});
                check({e.nm, ".b.stall"},  {7'd0, bus_b.stall},  {7'd0, e.b_st});
            end
        end
        if (chk_dq) begin
            if (dq.size() == 0) begin
                n_assert++; n_fail++;
                $display("FAIL data_queue: got empty expected entry");
            end else begin
                dexp_t e;
                e = dq.pop_front();
                check({e.nm, ".a.out0"}, bus_a.data_out0, e.a0);
                check({e.nm, ".a.out1"}, bus_a.data_out1, e.a1);
                check({e.nm, ".b.out0"}, bus_b.data_out0, e.b0);
                check({e.nm, ".b.out1"}, bus_b.data_out1, e.b1);
            end
        end
    end

    task automatic drive(input logic rst, input logic rd, input logic [3:0] a, input logic [3:0] b,
                         input logic wr, input logic [3:0] wa, input logic [7:0] wd,
                         input logic iss, input logic [3:0] ia);
        reset = rst; rd_en = rd; ra = a; rb = b;
        wr_en = wr; wd_addr = wa; wr_data = wd;
        issue_en = iss; issue_addr = ia;
        chk_c = 1'b0; chk_d = 1'b0;
    endtask

    task automatic exp_data(input string nm, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] b0, input logic [7:0] b1);
        dexp_t e;
        e.nm = nm; e.a0 = a0; e.a1 = a1; e.b0 = b0; e.b1 = b1;
        dq.push_back(e);
        chk_d = 1'b1;
    endtask

    task automatic exp_comb(input string nm, input logic aba, input logic abb, input logic ast,
                            input logic bba, input logic bbb, input logic bst);
        cexp_t e;
        e.nm = nm;
        e.a_ba = aba; e.a_bb = abb; e.a_st = ast;
        e.b_ba = bba; e.b_bb = bbb; e.b_st = bst;
        cq.push_back(e);
        chk_c = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        tick();
        // reset wins over a simultaneous read, write and issue
        drive(1, 1, 3, 15, 1, 3, 8'h77, 1, 3);
        exp_data("rst_prio", 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        drive(0, 1, 3, 15, 0, 0, 8'h00, 0, 0);
        exp_comb("rst_busy", 0, 0, 0, 0, 0, 0);
        exp_data("rst_read", 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        // write then read
        drive(0, 0, 0, 0, 1, 5, 8'hA5, 0, 0);
        tick();
        drive(0, 1, 5, 0, 0, 0, 8'h00, 0, 0);
        exp_data("wr_rd", 8'hA5, 8'h00, 8'hA5, 8'h00);
        tick();
        // outputs hold with rd_en low
        drive(0, 0, 0, 0, 1, 5, 8'h11, 0, 0);
        exp_data("hold", 8'hA5, 8'h00, 8'hA5, 8'h00);
        tick();
        // same-cycle write/read collision on port 0
        drive(0, 1, 7, 5, 1, 7, 8'h3C, 0, 0);
        exp_data("bypass_a", 8'h3C, 8'h11, 8'h00, 8'h11);
        tick();
        drive(0, 1, 7, 7, 0, 0, 8'h00, 0, 0);
        exp_data("after_byp", 8'h3C, 8'h3C, 8'h3C, 8'h3C);
        tick();
        // collision on port 1
        drive(0, 1, 5, 9, 1, 9, 8'h5A, 0, 0);
        exp_data("bypass_b", 8'h11, 8'h5A, 8'h11, 8'h00);
        tick();
        // scoreboard: issue, hazard, completing write
        drive(0, 0, 0, 0, 0, 0, 8'h00, 1, 2);
        tick();
        drive(0, 1, 1, 2, 0, 0, 8'h00, 0, 0);
        exp_comb("sb_busy", 0, 1, 1, 0, 1, 1);
        tick();
        drive(0, 1, 1, 2, 1, 2, 8'h42, 0, 0);
        exp_comb("sb_wrcyc", 0, 0, 0, 0, 1, 1);
        exp_data("sb_wrdata", 8'h00, 8'h42, 8'h00, 8'h00);
        tick();
        drive(0, 1, 1, 2, 0, 0, 8'h00, 0, 0);
        exp_comb("sb_clear", 0, 0, 0, 0, 0, 0);
        exp_data("sb_after", 8'h00, 8'h42, 8'h00, 8'h42);
        tick();
        // busy_a visible without rd_en; stall stays low
        drive(0, 0, 0, 0, 0, 0, 8'h00, 1, 6);
        tick();
        drive(0, 0, 6, 0, 0, 0, 8'h00, 0, 0);
        exp_comb("busy_nord", 1, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 6, 8'h66, 0, 0);
        tick();
        // set wins over clear on the same entry
        drive(0, 0, 0, 0, 1, 4, 8'hC3, 1, 4);
        tick();
        drive(0, 1, 4, 4, 0, 0, 8'h00, 0, 0);
        exp_comb("set_wins", 1, 1, 1, 1, 1, 1);
        exp_data("set_wins_d", 8'hC3, 8'hC3, 8'hC3, 8'hC3);
        tick();
        // entry 0: normal on dut_a, hardwired zero on dut_b
        drive(0, 0, 0, 0, 1, 0, 8'hFF, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 8'h00, 1, 0);
        tick();
        drive(0, 1, 0, 3, 0, 0, 8'h00, 0, 0);
        exp_comb("zero_busy", 1, 0, 1, 0, 0, 0);
        exp_data("zero_read", 8'hFF, 8'h00, 8'h00, 8'h00);
        tick();
        drive(0, 1, 0, 0, 1, 0, 8'h81, 0, 0);
        exp_comb("zero_byp_c", 0, 0, 0, 0, 0, 0);
        exp_data("zero_byp", 8'h81, 8'h81, 8'h00, 8'h00);
        tick();
        // top address, no aliasing onto lower entries
        drive(0, 0, 0, 0, 1, 15, 8'hE1, 0, 0);
        tick();
        drive(0, 1, 15, 7, 0, 0, 8'h00, 0, 0);
        exp_data("top_addr", 8'hE1, 8'h3C, 8'hE1, 8'h3C);
        tick();
        // reset mid-operation discards that cycle's write and issue
        drive(1, 0, 0, 0, 1, 8, 8'h99, 1, 8);
        tick();
        drive(0, 1, 8, 5, 0, 0, 8'h00, 0, 0);
        exp_comb("midrst_c", 0, 0, 0, 0, 0, 0);
        exp_data("midrst_d", 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        drive(0, 0, 0, 0, 1, 8, 8'h99, 0, 0);
        tick();
        drive(0, 1, 8, 0, 0, 0, 8'h00, 0, 0);
        exp_data("resume", 8'h99, 8'h00, 8'h99, 8'h00);
        tick();
        drive(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4 && (dq.size() != 0 || cq.size() != 0); i++) tick();
        tick();
        n_assert++;
        if (dq.size() != 0 || cq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", dq.size() + cq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
